// File: rtl/sdram_arbiter.sv
// Two-way SDRAM port arbiter: I-cache line fills vs. single-word CPU data accesses,
// with D-side anti-starvation and a no-progress watchdog that aborts stuck transactions.
module sdram_arbiter #(
  parameter int ADDR_W          = 21,
  parameter int BURST_LEN       = 16,
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_data,
  output logic              i_ack,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [4:0]        m_len,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wmask,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic              m_wdone,
  output logic              err,
  output logic              busy,
  output logic              owner
);

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_I_CMD  = 3'd1;
  localparam logic [2:0] S_I_DATA = 3'd2;
  localparam logic [2:0] S_D_CMD  = 3'd3;
  localparam logic [2:0] S_D_WAIT = 3'd4;
  localparam logic [2:0] S_REL    = 3'd5;

  localparam logic [4:0]          I_LEN      = 5'(BURST_LEN);
  localparam logic [ADDR_W-1:0]   LINE_MASK  = ~ADDR_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK_MAX);

  logic [2:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [4:0]          m_len_q, m_len_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [3:0]          m_wmask_q, m_wmask_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic gnt_iside, gnt_dside;
  logic wd_active, progress, wd_expire;
  logic fill_beat, fill_last, d_complete;

  // D normally wins a tie; a saturated streak hands the next grant to I.
  assign gnt_dside = (state_q == S_IDLE) && d_req && !(i_req && (streak_q == STREAK_MAX));
  assign gnt_iside = (state_q == S_IDLE) && i_req && !gnt_dside;

  assign wd_active = (state_q == S_I_CMD) || (state_q == S_I_DATA) ||
                     (state_q == S_D_CMD) || (state_q == S_D_WAIT);
  assign progress  = m_gnt || m_rvalid || m_wdone;
  assign wd_expire = wd_active && !progress && (wd_cnt_q == WD_LAST);

  assign fill_beat  = (state_q == S_I_DATA) && m_rvalid;
  assign fill_last  = fill_beat && (beat_cnt_q == BEAT_LAST);
  assign d_complete = (state_q == S_D_WAIT) && (m_we_q ? m_wdone : m_rvalid);

  assign i_data  = m_rdata;
  assign i_ack   = fill_beat;
  assign i_done  = fill_last || (wd_expire && !owner_q);
  assign d_ack   = (state_q == S_REL) && owner_q;
  assign d_rdata = d_rdata_q;
  assign err     = wd_expire;
  assign busy    = (state_q != S_IDLE);
  assign owner   = owner_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_len   = m_len_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;

  always_comb begin
    if (!i_req || gnt_iside) begin
      streak_d = '0;
    end else if (gnt_dside && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end else begin
      streak_d = streak_q;
    end
  end

  always_comb begin
    if (!wd_active || progress || wd_expire) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_len_d    = m_len_q;
    m_wdata_d  = m_wdata_q;
    m_wmask_d  = m_wmask_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (gnt_dside) begin
          state_d   = S_D_CMD;
          owner_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_len_d   = 5'd1;
          m_wdata_d = d_wdata;
          m_wmask_d = d_wmask;
        end else if (gnt_iside) begin
          state_d   = S_I_CMD;
          owner_d   = 1'b0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr & LINE_MASK;
          m_len_d   = I_LEN;
          m_wdata_d = '0;
          m_wmask_d = '0;
        end
      end
      S_I_CMD: begin
        if (m_gnt) begin
          state_d    = S_I_DATA;
          m_req_d    = 1'b0;
          beat_cnt_d = '0;
        end
      end
      S_I_DATA: begin
        if (fill_beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (fill_last) begin
            state_d = S_REL;
          end
        end
      end
      S_D_CMD: begin
        if (m_gnt) begin
          state_d = S_D_WAIT;
          m_req_d = 1'b0;
        end
      end
      S_D_WAIT: begin
        if (d_complete) begin
          state_d = S_REL;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
      end
    endcase

    // An abort never coincides with a progress event, so it cannot clash with the case above.
    if (wd_expire) begin
      state_d = S_REL;
      m_req_d = 1'b0;
      if (owner_q) begin
        d_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      streak_q   <= '0;
      beat_cnt_q <= '0;
      wd_cnt_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_len_q    <= '0;
      m_wdata_q  <= '0;
      m_wmask_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      beat_cnt_q <= beat_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_len_q    <= m_len_d;
      m_wdata_q  <= m_wdata_d;
      m_wmask_q  <= m_wmask_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: fills, data read/write, starvation, watchdog, mid-fill reset.
module tb_sdram_arbiter;

  localparam int ADDR_W          = 21;
  localparam int BURST_LEN       = 16;
  localparam int DATA_STREAK_MAX = 4;
  localparam int TIMEOUT         = 1024;

  logic              cpu_clk = 1'b0;
  logic              reset_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic              i_ack;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [4:0]        m_len;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wmask;
  logic              m_gnt;
  logic              m_rvalid;
  logic [31:0]       m_rdata;
  logic              m_wdone;
  logic              err;
  logic              busy;
  logic              owner;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 cpu_clk = ~cpu_clk;

  sdram_arbiter #(
    .ADDR_W(ADDR_W),
    .BURST_LEN(BURST_LEN),
    .DATA_STREAK_MAX(DATA_STREAK_MAX),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .cpu_clk(cpu_clk),
    .reset_n(reset_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_data(i_data),
    .i_ack(i_ack),
    .i_done(i_done),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wmask(d_wmask),
    .d_rdata(d_rdata),
    .d_ack(d_ack),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_len(m_len),
    .m_wdata(m_wdata),
    .m_wmask(m_wmask),
    .m_gnt(m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata(m_rdata),
    .m_wdone(m_wdone),
    .err(err),
    .busy(busy),
    .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Serves whichever requester the arbiter grants next; returns the owner it saw.
  task automatic serve(output logic own);
    int n;
    n = 0;
    while (m_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("serve_req", 32'(m_req), 1);
    own = owner;
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    if (own) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'h0BAD_F00D;
      tick();
      m_rvalid = 1'b0;
      check("serve_dack", 32'(d_ack), 1);
      check("serve_drdata", d_rdata, 32'h0BAD_F00D);
      tick();
    end else begin
      for (int k = 0; k < BURST_LEN; k++) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'(k);
        #1;
        if (k == BURST_LEN - 1) begin
          check("serve_idone", 32'(i_done), 1);
          i_req = 1'b0;
        end
        tick();
      end
      m_rvalid = 1'b0;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic       own;
    logic [5:0] exp_own = 6'b101111;
    int         n;
    int         beats;

    reset_n  = 1'b0;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_wmask  = '0;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_wdone  = 1'b0;
    #12;
    check("rst_busy",   32'(busy),   0);
    check("rst_mreq",   32'(m_req),  0);
    check("rst_owner",  32'(owner),  0);
    check("rst_maddr",  32'(m_addr), 0);
    check("rst_mlen",   32'(m_len),  0);
    check("rst_dack",   32'(d_ack),  0);
    check("rst_err",    32'(err),    0);
    check("rst_idone",  32'(i_done), 0);
    check("rst_drdata", d_rdata,     0);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    tick();

    // I-only line fill
    i_req  = 1'b1;
    i_addr = 21'h00123;
    tick();
    check("fill_mreq",  32'(m_req),  1);
    check("fill_maddr", 32'(m_addr), 32'h120);
    check("fill_mlen",  32'(m_len),  16);
    check("fill_mwe",   32'(m_we),   0);
    check("fill_owner", 32'(owner),  0);
    check("fill_busy",  32'(busy),   1);
    tick();
    tick();
    check("fill_mreq_held",  32'(m_req),  1);
    check("fill_maddr_held", 32'(m_addr), 32'h120);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    check("fill_mreq_drop", 32'(m_req), 0);
    for (int k = 0; k < 16; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hA000_0000 + 32'(k);
      #1;
      check("fill_iack",  32'(i_ack),  1);
      check("fill_idata", i_data,      32'hA000_0000 + 32'(k));
      check("fill_idone", 32'(i_done), 32'(k == 15));
      if (k == 15) i_req = 1'b0;
      tick();
    end
    check("fill_extra_beat_ignored", 32'(i_ack), 0);
    check("fill_rel_busy", 32'(busy), 1);
    m_rvalid = 1'b0;
    tick();
    check("fill_idle_busy", 32'(busy), 0);

    // D write
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 21'h1F0000;
    d_wdata = 32'hDEAD_BEEF;
    d_wmask = 4'b0011;
    tick();
    check("wr_mreq",   32'(m_req),   1);
    check("wr_mwe",    32'(m_we),    1);
    check("wr_maddr",  32'(m_addr),  32'h1F0000);
    check("wr_mlen",   32'(m_len),   1);
    check("wr_mwdata", m_wdata,      32'hDEAD_BEEF);
    check("wr_mwmask", 32'(m_wmask), 32'h3);
    check("wr_owner",  32'(owner),   1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    check("wr_mreq_drop", 32'(m_req), 0);
    tick();
    m_wdone = 1'b1;
    #1;
    check("wr_dack_early", 32'(d_ack), 0);
    tick();
    m_wdone = 1'b0;
    check("wr_dack", 32'(d_ack), 1);
    d_req = 1'b0;
    tick();
    check("wr_dack_pulse", 32'(d_ack), 0);
    check("wr_idle", 32'(busy), 0);

    // D read
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 21'h10;
    d_wmask = 4'b0000;
    tick();
    check("rd_mwe",   32'(m_we),   0);
    check("rd_maddr", 32'(m_addr), 32'h10);
    m_gnt = 1'b1;
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 32'h1234_5678;
    #1;
    check("rd_no_iack", 32'(i_ack), 0);
    check("rd_dack_early", 32'(d_ack), 0);
    tick();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    check("rd_dack",   32'(d_ack), 1);
    check("rd_drdata", d_rdata,    32'h1234_5678);
    d_req = 1'b0;
    tick();

    // Starvation: four D grants, then I, then D again
    i_req  = 1'b1;
    i_addr = 21'h40;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 21'h20;
    for (int g = 0; g < 6; g++) begin
      serve(own);
      check("starve_owner", 32'(own), 32'(exp_own[g]));
    end
    d_req = 1'b0;
    i_req = 1'b0;
    tick();
    check("starve_idle", 32'(busy), 0);

    // Watchdog abort of a D read that never returns data
    d_req  = 1'b1;
    d_addr = 21'h33;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    n = 0;
    while (!err && n < 2 * TIMEOUT) begin
      tick();
      n++;
    end
    check("wd_cycles", 32'(n), TIMEOUT - 1);
    check("wd_err", 32'(err), 1);
    check("wd_no_idone", 32'(i_done), 0);
    tick();
    check("wd_dack",   32'(d_ack), 1);
    check("wd_drdata", d_rdata,    0);
    check("wd_err_pulse", 32'(err), 0);
    d_req = 1'b0;
    tick();
    i_req  = 1'b1;
    i_addr = 21'h200;
    serve(own);
    check("wd_next_ifill", 32'(own), 0);
    tick();

    // Reset in the middle of a fill
    i_req  = 1'b1;
    i_addr = 21'h300;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'(k);
      tick();
    end
    m_rvalid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_busy",  32'(busy),   0);
    check("mrst_mreq",  32'(m_req),  0);
    check("mrst_maddr", 32'(m_addr), 0);
    check("mrst_mlen",  32'(m_len),  0);
    m_rvalid = 1'b1;
    #1;
    check("mrst_iack", 32'(i_ack), 0);
    m_rvalid = 1'b0;
    @(negedge cpu_clk);
    reset_n = 1'b1;
    tick();
    check("refill_mreq",  32'(m_req),  1);
    check("refill_maddr", 32'(m_addr), 32'h300);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    beats = 0;
    for (int k = 0; k < 16; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hC000_0000 + 32'(k);
      #1;
      if (i_ack) beats++;
      check("refill_idone", 32'(i_done), 32'(k == 15));
      if (k == 15) i_req = 1'b0;
      tick();
    end
    m_rvalid = 1'b0;
    check("refill_beats", 32'(beats), 16);
    tick();
    check("refill_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
